// File: rtl/fifo_pkg.sv
// Shared types, default sizes and helpers for the synchronous FIFO.
package fifo_pkg;

  typedef enum logic [1:0] {
    lectura,
    escritura,
    reset
  } tipo_trans;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  // Pointer width needed to index 'd' entries.
  function automatic int ptr_w(input int d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write, combinational read, no reset.
module fifo_mem #(
  parameter int width = 16,
  parameter int depth = 8,
  parameter int aw    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  // Write port: contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with registered status flags
// and one-cycle overflow/underflow pulses for illegal accesses.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int width = FIFO_WIDTH_DEF,
  parameter int depth = FIFO_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [width-1:0]             dato_in,
  output logic [width-1:0]             dato_out,
  output logic                         pndng,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int aw = ptr_w(depth);
  localparam int cw = $clog2(depth + 1);

  logic [aw-1:0]    wr_ptr;
  logic [aw-1:0]    rd_ptr;
  logic [cw-1:0]    count_nxt;
  logic [width-1:0] rdata;
  logic             do_push;
  logic             do_pop;
  logic             ovf_nxt;
  logic             unf_nxt;

  fifo_mem #(
    .width (width),
    .depth (depth),
    .aw    (aw)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (dato_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Accept decisions: a full FIFO still takes a push when a pop frees the head
  // in the same cycle; a pop on empty is ignored even with a concurrent push.
  always_comb begin
    do_push   = push && (!full || pop);
    do_pop    = pop && pndng;
    ovf_nxt   = push && full && !pop;
    unf_nxt   = pop && !pndng;
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + cw'(1);
      2'b01:   count_nxt = count - cw'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy, flags and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pndng     <= 1'b0;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + aw'(1);
      if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
      count     <= count_nxt;
      pndng     <= (count_nxt != '0);
      full      <= (count_nxt == cw'(depth));
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

  assign dato_out = (count == '0) ? '0 : rdata;

endmodule
